// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch front end: the sequencer
// state encoding, the sequential PC increment and the default reset vector.
// No ports; imported by fetch_sequencer and next_pc_select.
// ---------------------------------------------------------------------------
package fetch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DRAIN = 2'd3
   } fetch_state_e;

   localparam int unsigned PC_INCR            = 4;
   localparam logic [31:0] RESET_ADDR_DEFAULT = 32'h0000_0000;

endpackage : fetch_pkg

// File: rtl/next_pc_select.sv
// ---------------------------------------------------------------------------
// next_pc_select
// Combinational priority mux that produces the PC fed back to the program
// counter. Priority: reset vector, redirect target (jump over branch),
// pending redirect target, fetched address + 4, hold current PC.
//
// Ports:
//   sel_reset_i       force the reset vector
//   sel_redirect_i    take the live redirect target
//   sel_pending_i     take the latched redirect target
//   sel_incr_i        take fetch_addr_i + 4
//   jump_i            jump wins over branch when both redirect
//   jump_target_i     raw jump destination
//   branch_target_i   raw branch destination
//   pending_i         latched redirect target
//   fetch_addr_i      address of the fetch that just completed
//   pc_hold_i         current PC (used when nothing else applies)
//   redirect_target_o word-aligned redirect destination
//   pc_next_o         selected next PC
// ---------------------------------------------------------------------------
module next_pc_select
   import fetch_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = ADDR_WIDTH'(RESET_ADDR_DEFAULT)
) (
   input  logic                  sel_reset_i,
   input  logic                  sel_redirect_i,
   input  logic                  sel_pending_i,
   input  logic                  sel_incr_i,
   input  logic                  jump_i,
   input  logic [ADDR_WIDTH-1:0] jump_target_i,
   input  logic [ADDR_WIDTH-1:0] branch_target_i,
   input  logic [ADDR_WIDTH-1:0] pending_i,
   input  logic [ADDR_WIDTH-1:0] fetch_addr_i,
   input  logic [ADDR_WIDTH-1:0] pc_hold_i,
   output logic [ADDR_WIDTH-1:0] redirect_target_o,
   output logic [ADDR_WIDTH-1:0] pc_next_o
);

   logic [ADDR_WIDTH-1:0] rawTarget;
   logic [ADDR_WIDTH-1:0] alignedTarget;

   // Jump takes priority over branch; the low two bits are cleared so every
   // redirect lands on a word boundary regardless of what decode supplied.
   always_comb begin
      rawTarget     = jump_i ? jump_target_i : branch_target_i;
      alignedTarget = {rawTarget[ADDR_WIDTH-1:2], 2'b00};
   end

   assign redirect_target_o = alignedTarget;

   // Fixed-priority selection. The increment wraps modulo 2^ADDR_WIDTH on
   // purpose: running off the top of the address space simply restarts at 0.
   always_comb begin
      pc_next_o = pc_hold_i;
      if (sel_reset_i) begin
         pc_next_o = RESET_ADDR;
      end else if (sel_redirect_i) begin
         pc_next_o = alignedTarget;
      end else if (sel_pending_i) begin
         pc_next_o = pending_i;
      end else if (sel_incr_i) begin
         pc_next_o = fetch_addr_i + ADDR_WIDTH'(PC_INCR);
      end
   end

endmodule : next_pc_select

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
// Instruction-fetch front end sitting upstream of program_counter. It reads
// the registered PC back, fetches the instruction at that PC over a
// req/ready handshake, and presents it to decode in a single-entry
// valid/accept slot. Branch/jump redirects arrive with instr_accept; a
// redirect that races an outstanding request lets that request finish and
// throws its data away before fetching from the new target.
//
// Ports:
//   clock, reset_n   rising-edge clock, asynchronous active-low reset
//   pc_out_addr      current PC from program_counter
//   pc_in_addr       next PC to program_counter (combinational)
//   imem_req/addr    memory request and its registered address
//   imem_ready/rdata memory completion and returned instruction
//   instr_valid      instr/instr_pc hold a fetched instruction
//   instr, instr_pc  fetched instruction and its address
//   instr_accept     decode consumes instr this cycle
//   branch_taken/branch_target, jump/jump_target
//                    redirect requests, qualified by instr_accept
// ---------------------------------------------------------------------------
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter int unsigned           DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = ADDR_WIDTH'(RESET_ADDR_DEFAULT)
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [ADDR_WIDTH-1:0] pc_out_addr,
   output logic [ADDR_WIDTH-1:0] pc_in_addr,
   output logic                  imem_req,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic                  imem_ready,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
   output logic                  instr_valid,
   output logic [DATA_WIDTH-1:0] instr,
   output logic [ADDR_WIDTH-1:0] instr_pc,
   input  logic                  instr_accept,
   input  logic                  branch_taken,
   input  logic [ADDR_WIDTH-1:0] branch_target,
   input  logic                  jump,
   input  logic [ADDR_WIDTH-1:0] jump_target
);

   fetch_state_e          state_q, state_d;
   logic                  req_q, req_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  valid_q, valid_d;
   logic [DATA_WIDTH-1:0] instr_q, instr_d;
   logic [ADDR_WIDTH-1:0] ipc_q, ipc_d;
   logic [ADDR_WIDTH-1:0] pending_q, pending_d;

   logic                  redirectReq;
   logic                  selReset;
   logic                  selRedirect;
   logic                  selPending;
   logic                  selIncr;
   logic [ADDR_WIDTH-1:0] redirectTarget;

   // A redirect only counts when decode actually consumes this cycle.
   assign redirectReq = instr_accept & (jump | branch_taken);

   // Next-state and output-register logic. The slot is only refilled once it
   // is empty or being consumed, so while a request is outstanding the slot
   // is always empty; that is why WAIT never has to arbitrate for it. A
   // redirect during an outstanding request cannot cancel the memory side
   // (imem_req must stay up until imem_ready), so the target is parked in
   // pending_q and the returning data is dropped in DRAIN.
   always_comb begin
      state_d     = state_q;
      req_d       = req_q;
      addr_d      = addr_q;
      valid_d     = valid_q;
      instr_d     = instr_q;
      ipc_d       = ipc_q;
      pending_d   = pending_q;
      selReset    = 1'b0;
      selRedirect = 1'b0;
      selPending  = 1'b0;
      selIncr     = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            selReset = 1'b1;
            state_d  = ST_FETCH;
         end

         ST_FETCH: begin
            if (redirectReq) begin
               selRedirect = 1'b1;
               valid_d     = 1'b0;
            end else if (!valid_q || instr_accept) begin
               req_d   = 1'b1;
               addr_d  = pc_out_addr;
               valid_d = 1'b0;
               state_d = ST_WAIT;
            end
         end

         ST_WAIT: begin
            if (redirectReq) begin
               valid_d = 1'b0;
               if (imem_ready) begin
                  req_d       = 1'b0;
                  selRedirect = 1'b1;
                  state_d     = ST_FETCH;
               end else begin
                  pending_d = redirectTarget;
                  state_d   = ST_DRAIN;
               end
            end else if (imem_ready) begin
               instr_d = imem_rdata;
               ipc_d   = addr_q;
               valid_d = 1'b1;
               req_d   = 1'b0;
               selIncr = 1'b1;
               state_d = ST_FETCH;
            end
         end

         ST_DRAIN: begin
            if (redirectReq) begin
               valid_d = 1'b0;
               if (imem_ready) begin
                  req_d       = 1'b0;
                  selRedirect = 1'b1;
                  state_d     = ST_FETCH;
               end else begin
                  pending_d = redirectTarget;
               end
            end else if (imem_ready) begin
               req_d      = 1'b0;
               selPending = 1'b1;
               state_d    = ST_FETCH;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers. Reset is asynchronous so an in-flight
   // request is dropped immediately without waiting for imem_ready.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         req_q     <= 1'b0;
         addr_q    <= '0;
         valid_q   <= 1'b0;
         instr_q   <= '0;
         ipc_q     <= '0;
         pending_q <= '0;
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         addr_q    <= addr_d;
         valid_q   <= valid_d;
         instr_q   <= instr_d;
         ipc_q     <= ipc_d;
         pending_q <= pending_d;
      end
   end

   // While reset is held the program counter must see the reset vector,
   // not whatever the hold path would otherwise select.
   next_pc_select #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .RESET_ADDR (RESET_ADDR)
   ) u_next_pc_select (
      .sel_reset_i       (selReset | ~reset_n),
      .sel_redirect_i    (selRedirect),
      .sel_pending_i     (selPending),
      .sel_incr_i        (selIncr),
      .jump_i            (jump),
      .jump_target_i     (jump_target),
      .branch_target_i   (branch_target),
      .pending_i         (pending_q),
      .fetch_addr_i      (addr_q),
      .pc_hold_i         (pc_out_addr),
      .redirect_target_o (redirectTarget),
      .pc_next_o         (pc_in_addr)
   );

   assign imem_req    = req_q;
   assign imem_addr   = addr_q;
   assign instr_valid = valid_q;
   assign instr       = instr_q;
   assign instr_pc    = ipc_q;

endmodule : fetch_sequencer

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer
// Drives fetch_sequencer with a stand-in program counter register and a
// memory that answers after a chosen number of wait cycles. A transaction
// view of the front end (is a fetch in flight, is it doomed by a redirect,
// what sits in the decode slot) predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;

   localparam logic [31:0] RESET_ADDR   = 32'h0000_0000;
   localparam logic [31:0] PC_RESET_VAL = 32'h0000_1230;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [31:0] pc_out_addr;
   logic [31:0] pc_in_addr;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_accept;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        jump;
   logic [31:0] jump_target;

   int compared   = 0;
   int mismatched = 0;

   bit          mStarted;
   bit          mBusy;
   bit          mDrop;
   bit          mSlotValid;
   logic [31:0] mPc;
   logic [31:0] mReqAddr;
   logic [31:0] mDropTgt;
   logic [31:0] mSlotData;
   logic [31:0] mSlotPc;
   int          waitCnt;
   int          curLat;
   int          forcedLat = -1;
   bit          prevReq;
   logic [31:0] reqLog[$];

   fetch_sequencer dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .pc_out_addr   (pc_out_addr),
      .pc_in_addr    (pc_in_addr),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ready    (imem_ready),
      .imem_rdata    (imem_rdata),
      .instr_valid   (instr_valid),
      .instr         (instr),
      .instr_pc      (instr_pc),
      .instr_accept  (instr_accept),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump          (jump),
      .jump_target   (jump_target)
   );

   always #5 clock = ~clock;

   // Stand-in for program_counter: registers whatever the sequencer asks for.
   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) pc_out_addr <= PC_RESET_VAL;
      else          pc_out_addr <= pc_in_addr;
   end

   // Memory contents are a fixed scramble of the address, so any returned
   // word identifies which address was actually fetched.
   function automatic logic [31:0] memWord(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
      end
   endtask

   task automatic resetModel();
      mStarted   = 1'b0;
      mBusy      = 1'b0;
      mDrop      = 1'b0;
      mSlotValid = 1'b0;
      mPc        = PC_RESET_VAL;
      mReqAddr   = '0;
      mDropTgt   = '0;
      mSlotData  = '0;
      mSlotPc    = '0;
      waitCnt    = 0;
      curLat     = 0;
      prevReq    = 1'b0;
      reqLog.delete();
   endtask

   // One clock cycle: drive inputs at the falling edge, compare everything
   // the model predicts, then advance the model to the next rising edge.
   task automatic applyStimulus(input bit acc, input bit jmp, input logic [31:0] jt,
                                input bit br, input logic [31:0] bt);
      logic [31:0] expPc;
      logic [31:0] tgt;
      bit          redir;
      bit          ready;
      @(negedge clock);
      if (imem_req && !prevReq) reqLog.push_back(imem_addr);
      prevReq       = imem_req;
      instr_accept  = acc;
      jump          = jmp;
      jump_target   = jt;
      branch_taken  = br;
      branch_target = bt;
      ready         = mBusy && (waitCnt == curLat);
      imem_ready    = ready;
      imem_rdata    = ready ? memWord(mReqAddr) : $urandom;
      #1;
      checkOutput("imem_req", 32'(imem_req), 32'(mBusy));
      checkOutput("imem_addr", imem_addr, mReqAddr);
      checkOutput("instr_valid", 32'(instr_valid), 32'(mSlotValid));
      checkOutput("instr", instr, mSlotData);
      checkOutput("instr_pc", instr_pc, mSlotPc);

      redir   = acc && (jmp || br);
      tgt     = jmp ? jt : bt;
      tgt[1:0] = 2'b00;
      expPc   = mPc;
      if (!mStarted) begin
         expPc    = RESET_ADDR;
         mStarted = 1'b1;
      end else if (!mBusy) begin
         if (redir) begin
            expPc      = tgt;
            mSlotValid = 1'b0;
         end else if (!mSlotValid || acc) begin
            mSlotValid = 1'b0;
            mBusy      = 1'b1;
            mDrop      = 1'b0;
            mReqAddr   = mPc;
            waitCnt    = 0;
            curLat     = (forcedLat >= 0) ? forcedLat : int'($urandom_range(0, 3));
         end
      end else if (redir) begin
         mSlotValid = 1'b0;
         if (ready) begin
            mBusy = 1'b0;
            mDrop = 1'b0;
            expPc = tgt;
         end else begin
            mDrop    = 1'b1;
            mDropTgt = tgt;
            waitCnt++;
         end
      end else if (ready) begin
         mBusy = 1'b0;
         if (mDrop) begin
            mDrop = 1'b0;
            expPc = mDropTgt;
         end else begin
            mSlotValid = 1'b1;
            mSlotData  = memWord(mReqAddr);
            mSlotPc    = mReqAddr;
            expPc      = mReqAddr + 32'd4;
         end
      end else begin
         waitCnt++;
      end
      checkOutput("pc_in_addr", pc_in_addr, expPc);
      mPc = expPc;
   endtask

   task automatic settle();
      @(posedge clock);
      #1;
   endtask

   task automatic doReset();
      settle();
      #2;
      reset_n      = 1'b0;
      instr_accept = 1'b0;
      jump         = 1'b0;
      branch_taken = 1'b0;
      imem_ready   = 1'b0;
      resetModel();
      repeat (2) @(posedge clock);
      #2;
      reset_n = 1'b1;
   endtask

   // Accept every instruction until the model holds the one at addr.
   task automatic runUntilSlot(input logic [31:0] addr, input string tag);
      bit found = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (mSlotValid && mSlotPc == addr) begin
            found = 1'b1;
            break;
         end
         applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      end
      checkOutput(tag, 32'(found), 32'd1);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit done;
      reset_n       = 1'b1;
      instr_accept  = 1'b0;
      jump          = 1'b0;
      jump_target   = '0;
      branch_taken  = 1'b0;
      branch_target = '0;
      imem_ready    = 1'b0;
      imem_rdata    = '0;
      resetModel();
      #1 reset_n = 1'b0;
      #2;
      checkOutput("rst_imem_req", 32'(imem_req), 32'd0);
      checkOutput("rst_imem_addr", imem_addr, 32'd0);
      checkOutput("rst_instr_valid", 32'(instr_valid), 32'd0);
      checkOutput("rst_instr", instr, 32'd0);
      checkOutput("rst_instr_pc", instr_pc, 32'd0);
      checkOutput("rst_pc_in_addr", pc_in_addr, RESET_ADDR);
      repeat (2) @(posedge clock);
      #2 reset_n = 1'b1;

      $display("[TB] sequential fetch, ready one cycle after request");
      forcedLat = 1;
      for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput("seq_req0", reqLog[0], 32'h0);
      checkOutput("seq_req1", reqLog[1], 32'h4);
      checkOutput("seq_req2", reqLog[2], 32'h8);

      $display("[TB] decode stall with a valid instruction");
      done = 1'b0;
      for (int i = 0; i < 10 && !done; i++) begin
         applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
         done = mSlotValid;
      end
      checkOutput("stall_reach_valid", 32'(done), 32'd1);
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      settle();
      checkOutput("stall_req_low", 32'(imem_req), 32'd0);
      checkOutput("stall_instr", instr, memWord(mSlotPc));

      $display("[TB] jump beats branch on accept");
      doReset();
      runUntilSlot(32'h10, "jump_reach_0x10");
      applyStimulus(1'b1, 1'b1, 32'h12AC_E47B, 1'b1, 32'h0000_0040);
      settle();
      checkOutput("jump_valid_drop", 32'(instr_valid), 32'd0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput("jump_req_addr", reqLog[$], 32'h12AC_E478);

      $display("[TB] redirect while a request is outstanding");
      doReset();
      runUntilSlot(32'h10, "drain_reach_0x10");
      forcedLat = 3;
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0040);
      for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput("drain_first_req", reqLog[reqLog.size() - 2], 32'h14);
      checkOutput("drain_next_req", reqLog[$], 32'h40);
      checkOutput("drain_no_valid", 32'(instr_valid), 32'd0);

      $display("[TB] PC wrap at the top of the address space");
      forcedLat = 0;
      applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0);
      done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
         done = mSlotValid;
      end
      checkOutput("wrap_reach_valid", 32'(done), 32'd1);
      settle();
      checkOutput("wrap_instr_pc", instr_pc, 32'hFFFF_FFFC);
      checkOutput("wrap_pc_zero", pc_out_addr, 32'h0);

      $display("[TB] asynchronous reset during an outstanding request");
      doReset();
      forcedLat = 3;
      done = 1'b0;
      for (int i = 0; i < 10 && !done; i++) begin
         applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
         done = mBusy;
      end
      checkOutput("areset_reach_busy", 32'(done), 32'd1);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      settle();
      #2;
      checkOutput("areset_pre_req", 32'(imem_req), 32'd1);
      reset_n = 1'b0;
      #1;
      checkOutput("areset_req", 32'(imem_req), 32'd0);
      checkOutput("areset_valid", 32'(instr_valid), 32'd0);
      checkOutput("areset_addr", imem_addr, 32'd0);
      checkOutput("areset_pc_in", pc_in_addr, RESET_ADDR);
      resetModel();
      repeat (2) @(posedge clock);
      #2 reset_n = 1'b1;
      forcedLat = -1;
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput("areset_first_req", reqLog[0], RESET_ADDR);

      $display("[TB] randomized traffic");
      doReset();
      forcedLat = -1;
      for (int i = 0; i < 1500; i++) begin
         logic [31:0] r1;
         logic [31:0] r2;
         r1 = $urandom;
         r2 = $urandom;
         if ($urandom_range(0, 3) == 0) r1 = 32'hFFFF_FFF0 | {28'd0, r1[3:0]};
         applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, r1,
                       $urandom_range(0, 7) == 0, r2);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule : tb_fetch_sequencer
